// File: rtl/cosim_stream_checker_if.sv
// Valid/ready handshake bundle for the golden and DUT result streams
// feeding the co-simulation checker.
interface cosim_stream_checker_if #(
  parameter int W = 11
);
  logic [W-1:0] gold_data;
  logic         gold_valid;
  logic         gold_ready;
  logic [W-1:0] dut_data;
  logic         dut_valid;
  logic         dut_ready;

  modport master (
    output gold_data, gold_valid, dut_data, dut_valid,
    input  gold_ready, dut_ready
  );

  modport slave (
    input  gold_data, gold_valid, dut_data, dut_valid,
    output gold_ready, dut_ready
  );
endinterface

// File: rtl/cosim_stream_checker.sv
// Compares a golden result stream against a DUT result stream pair by pair,
// with per-side skew FIFOs, match/error statistics, first-error capture and a stall watchdog.
module cosim_stream_checker #(
  parameter int W       = 11,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  cosim_stream_checker_if.slave stream,
  input  logic                 clear,
  input  logic                 stop_on_error,
  output logic [1:0]           status,
  output logic                 cmp_valid,
  output logic                 cmp_match,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [W-1:0]         first_err_gold,
  output logic [W-1:0]         first_err_dut
);
  localparam int AW = $clog2(DEPTH);
  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FAIL = 2'b10, TMO = 2'b11} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state;
  logic [W-1:0]     gold_mem [DEPTH];
  logic [W-1:0]     dut_mem  [DEPTH];
  logic [AW:0]      gold_wr, gold_rd, dut_wr, dut_rd;
  logic [CNT_W-1:0] pair_idx;
  logic [WD_W-1:0]  wd_cnt;

  logic gold_empty, gold_full, dut_empty, dut_full;
  logic frozen, pop, push_g, push_d, same, one_side, active, wd_expire;
  logic [W-1:0] gold_head, dut_head;

  assign gold_empty = (gold_wr == gold_rd);
  assign dut_empty  = (dut_wr == dut_rd);
  assign gold_full  = (gold_wr[AW] != gold_rd[AW]) && (gold_wr[AW-1:0] == gold_rd[AW-1:0]);
  assign dut_full   = (dut_wr[AW] != dut_rd[AW]) && (dut_wr[AW-1:0] == dut_rd[AW-1:0]);
  assign gold_head  = gold_mem[gold_rd[AW-1:0]];
  assign dut_head   = dut_mem[dut_rd[AW-1:0]];

  assign frozen = (state == TMO) || ((state == FAIL) && stop_on_error);
  assign pop    = !gold_empty && !dut_empty && !frozen && !clear;
  assign same   = (gold_head == dut_head);

  // A full FIFO may still accept when its head leaves on the same edge;
  // pop depends only on registered occupancy, so no valid-to-ready path exists.
  assign stream.gold_ready = _RESET && !clear && !frozen && (!gold_full || pop);
  assign stream.dut_ready  = _RESET && !clear && !frozen && (!dut_full || pop);
  assign push_g = stream.gold_valid && stream.gold_ready;
  assign push_d = stream.dut_valid && stream.dut_ready;

  assign one_side  = (gold_empty != dut_empty);
  assign active    = (state == RUN) || (state == FAIL);
  assign wd_expire = (TIMEOUT != 0) && active && one_side && (wd_cnt == WD_LAST);
  assign status    = state;

  always_ff @(posedge CLK) begin
    if (push_g) gold_mem[gold_wr[AW-1:0]] <= stream.gold_data;
    if (push_d) dut_mem[dut_wr[AW-1:0]]   <= stream.dut_data;
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state          <= IDLE;
      gold_wr        <= '0;
      gold_rd        <= '0;
      dut_wr         <= '0;
      dut_rd         <= '0;
      cmp_valid      <= 1'b0;
      cmp_match      <= 1'b0;
      match_cnt      <= '0;
      err_cnt        <= '0;
      pair_idx       <= '0;
      first_err_idx  <= '0;
      first_err_gold <= '0;
      first_err_dut  <= '0;
      wd_cnt         <= '0;
    end else if (clear) begin
      state          <= IDLE;
      gold_wr        <= '0;
      gold_rd        <= '0;
      dut_wr         <= '0;
      dut_rd         <= '0;
      cmp_valid      <= 1'b0;
      cmp_match      <= 1'b0;
      match_cnt      <= '0;
      err_cnt        <= '0;
      pair_idx       <= '0;
      first_err_idx  <= '0;
      first_err_gold <= '0;
      first_err_dut  <= '0;
      wd_cnt         <= '0;
    end else begin
      cmp_valid <= pop;
      cmp_match <= pop && same;
      if (push_g) gold_wr <= gold_wr + 1'b1;
      if (push_d) dut_wr  <= dut_wr + 1'b1;

      if (pop) begin
        gold_rd  <= gold_rd + 1'b1;
        dut_rd   <= dut_rd + 1'b1;
        pair_idx <= sat_inc(pair_idx);
        if (same) begin
          match_cnt <= sat_inc(match_cnt);
        end else begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == '0) begin
            first_err_idx  <= pair_idx;
            first_err_gold <= gold_head;
            first_err_dut  <= dut_head;
          end
        end
      end

      // Watchdog only runs while exactly one side is waiting for its partner.
      if (pop || !one_side || !active) wd_cnt <= '0;
      else if ((TIMEOUT != 0) && !wd_expire) wd_cnt <= wd_cnt + 1'b1;

      case (state)
        IDLE: if (push_g || push_d) state <= RUN;
        RUN: begin
          if (wd_expire) state <= TMO;
          else if (pop && !same) state <= FAIL;
        end
        FAIL: if (wd_expire) state <= TMO;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cosim_stream_checker.sv
// Directed bench for cosim_stream_checker: table-driven stream scenarios plus
// hand-written reset, clear, watchdog and saturation sequences.
module tb_cosim_stream_checker;
  localparam int W = 11;

  logic CLK = 1'b0;
  logic _RESET;
  always #5 CLK = ~CLK;

  cosim_stream_checker_if #(.W(W)) m ();
  cosim_stream_checker_if #(.W(W)) s ();

  logic        clear_m, stop_m, clear_s, stop_s;
  logic [1:0]  status_m, status_s;
  logic        cmp_valid_m, cmp_match_m, cmp_valid_s, cmp_match_s;
  logic [15:0] match_cnt_m, err_cnt_m, first_err_idx_m;
  logic [3:0]  match_cnt_s, err_cnt_s, first_err_idx_s;
  logic [W-1:0] first_err_gold_m, first_err_dut_m, first_err_gold_s, first_err_dut_s;

  cosim_stream_checker #(.W(W), .DEPTH(4), .CNT_W(16), .TIMEOUT(10)) u_main (
    .CLK(CLK), ._RESET(_RESET), .stream(m), .clear(clear_m), .stop_on_error(stop_m),
    .status(status_m), .cmp_valid(cmp_valid_m), .cmp_match(cmp_match_m),
    .match_cnt(match_cnt_m), .err_cnt(err_cnt_m), .first_err_idx(first_err_idx_m),
    .first_err_gold(first_err_gold_m), .first_err_dut(first_err_dut_m)
  );

  cosim_stream_checker #(.W(W), .DEPTH(4), .CNT_W(4), .TIMEOUT(0)) u_sat (
    .CLK(CLK), ._RESET(_RESET), .stream(s), .clear(clear_s), .stop_on_error(stop_s),
    .status(status_s), .cmp_valid(cmp_valid_s), .cmp_match(cmp_match_s),
    .match_cnt(match_cnt_s), .err_cnt(err_cnt_s), .first_err_idx(first_err_idx_s),
    .first_err_gold(first_err_gold_s), .first_err_dut(first_err_dut_s)
  );

  typedef struct {
    string name;
    int    n;
    int    dly;
    int    bad_i;
    int    bad_v;
    bit    stop;
    int    max_cyc;
    bit    exp_done;
    int    exp_match;
    int    exp_err;
    int    exp_status;
    int    exp_idx;
    int    exp_fg;
    int    exp_fd;
    int    exp_pulses;
    int    exp_run;
    int    exp_stall;
    bit    exp_frozen;
  } vec_t;

  vec_t tbl [5];
  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic pulse_clear();
    @(negedge CLK);
    clear_m = 1'b1;
    @(negedge CLK);
    clear_m = 1'b0;
  endtask

  task automatic run_stream(input int n, input int dly, input int bad_i, input logic [W-1:0] bad_v,
                            input int max_cyc, output bit done, output int pulses,
                            output int max_run, output int stalls);
    int gi, di, cyc, cur;
    bit ga, da;
    gi = 0; di = 0; cyc = 0; cur = 0;
    pulses = 0; max_run = 0; stalls = 0;
    while ((gi < n || di < n) && cyc < max_cyc) begin
      @(negedge CLK);
      m.gold_valid = (gi < n);
      m.gold_data  = W'(gi + 1);
      m.dut_valid  = (cyc >= dly) && (di < n);
      m.dut_data   = (di == bad_i) ? bad_v : W'(di + 1);
      #1;
      ga = m.gold_valid && m.gold_ready;
      da = m.dut_valid && m.dut_ready;
      if (m.gold_valid && !m.gold_ready) stalls++;
      @(posedge CLK);
      if (ga) gi++;
      if (da) di++;
      #1;
      if (cmp_valid_m) begin
        pulses++; cur++;
        if (cur > max_run) max_run = cur;
      end else cur = 0;
      cyc++;
    end
    done = (gi >= n) && (di >= n);
    @(negedge CLK);
    m.gold_valid = 1'b0;
    m.dut_valid  = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      if (cmp_valid_m) begin
        pulses++; cur++;
        if (cur > max_run) max_run = cur;
      end else cur = 0;
    end
  endtask

  initial begin
    bit done;
    int pulses, max_run, stalls, tmo_edge, sat_stall;

    tbl[0] = '{"lockstep", 100, 0, -1, 0,     0, 200, 1, 100, 0, 1, 0, 0, 0,     100, 100, 0, 0};
    tbl[1] = '{"skew3",    50,  3, -1, 0,     0, 200, 1, 50,  0, 1, 0, 0, 0,     50,  50,  0, 0};
    tbl[2] = '{"skew6",    50,  6, -1, 0,     0, 200, 1, 50,  0, 1, 0, 0, 0,     50,  -1,  1, 0};
    tbl[3] = '{"mismatch", 20,  0, 7,  'h055, 0, 200, 1, 19,  1, 2, 7, 8, 'h055, 20,  20,  -1, 0};
    tbl[4] = '{"stop_err", 20,  0, 2,  'h055, 1, 30,  0, 2,   1, 2, 2, 3, 'h055, 3,   3,   -1, 1};

    _RESET = 1'b0;
    clear_m = 1'b0; stop_m = 1'b0; clear_s = 1'b0; stop_s = 1'b0;
    m.gold_valid = 1'b0; m.dut_valid = 1'b0; m.gold_data = '0; m.dut_data = '0;
    s.gold_valid = 1'b0; s.dut_valid = 1'b0; s.gold_data = '0; s.dut_data = '0;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_status", status_m, 0);
    check("rst_gold_ready", m.gold_ready, 0);
    check("rst_dut_ready", m.dut_ready, 0);
    check("rst_match_cnt", match_cnt_m, 0);
    check("rst_cmp_valid", cmp_valid_m, 0);
    @(negedge CLK);
    _RESET = 1'b1;
    #1;
    check("post_rst_gold_ready", m.gold_ready, 1);

    for (int i = 0; i < 5; i++) begin
      pulse_clear();
      stop_m = tbl[i].stop;
      run_stream(tbl[i].n, tbl[i].dly, tbl[i].bad_i, W'(tbl[i].bad_v), tbl[i].max_cyc,
                 done, pulses, max_run, stalls);
      check({tbl[i].name, ":done"}, done, tbl[i].exp_done);
      check({tbl[i].name, ":match_cnt"}, match_cnt_m, tbl[i].exp_match);
      check({tbl[i].name, ":err_cnt"}, err_cnt_m, tbl[i].exp_err);
      check({tbl[i].name, ":status"}, status_m, tbl[i].exp_status);
      check({tbl[i].name, ":first_err_idx"}, first_err_idx_m, tbl[i].exp_idx);
      check({tbl[i].name, ":first_err_gold"}, first_err_gold_m, tbl[i].exp_fg);
      check({tbl[i].name, ":first_err_dut"}, first_err_dut_m, tbl[i].exp_fd);
      check({tbl[i].name, ":cmp_pulses"}, pulses, tbl[i].exp_pulses);
      if (tbl[i].exp_run >= 0) check({tbl[i].name, ":cmp_run"}, max_run, tbl[i].exp_run);
      if (tbl[i].exp_stall >= 0) check({tbl[i].name, ":gold_stall"}, (stalls > 0) ? 1 : 0, tbl[i].exp_stall);
      if (tbl[i].exp_frozen) begin
        check({tbl[i].name, ":gold_ready"}, m.gold_ready, 0);
        check({tbl[i].name, ":dut_ready"}, m.dut_ready, 0);
      end
    end

    // Clear out of the frozen FAIL state left by the last table entry.
    pulse_clear();
    #1;
    check("clr_status", status_m, 0);
    check("clr_match_cnt", match_cnt_m, 0);
    check("clr_err_cnt", err_cnt_m, 0);
    check("clr_first_err_idx", first_err_idx_m, 0);
    check("clr_first_err_dut", first_err_dut_m, 0);
    check("clr_cmp_valid", cmp_valid_m, 0);
    check("clr_gold_ready", m.gold_ready, 1);

    // Watchdog: one golden item with no partner.
    stop_m = 1'b0;
    @(negedge CLK);
    m.gold_valid = 1'b1; m.gold_data = W'(5);
    @(posedge CLK);
    #1;
    check("wd_run_status", status_m, 1);
    @(negedge CLK);
    m.gold_valid = 1'b0;
    tmo_edge = -1;
    for (int j = 1; j <= 20; j++) begin
      @(posedge CLK);
      #1;
      if (tmo_edge < 0 && status_m == 2'b11) tmo_edge = j;
    end
    check("wd_timeout_edge", tmo_edge, 10);
    check("wd_status", status_m, 3);
    check("wd_gold_ready", m.gold_ready, 0);
    check("wd_dut_ready", m.dut_ready, 0);

    // Saturation on the 4-bit counter instance.
    sat_stall = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLK);
      s.gold_valid = 1'b1; s.gold_data = W'(j);
      s.dut_valid  = 1'b1; s.dut_data  = W'(j);
      #1;
      if (!s.gold_ready || !s.dut_ready) sat_stall++;
    end
    @(negedge CLK);
    s.gold_valid = 1'b0; s.dut_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("sat_stall", sat_stall, 0);
    check("sat_match_cnt", match_cnt_s, 15);
    check("sat_err_cnt", err_cnt_s, 0);
    check("sat_status", status_s, 1);

    // Asynchronous reset mid-stream must also flush FIFO contents.
    pulse_clear();
    for (int j = 0; j < 2; j++) begin
      @(negedge CLK);
      m.gold_valid = 1'b1; m.gold_data = W'(j + 1);
    end
    @(negedge CLK);
    m.gold_valid = 1'b0;
    _RESET = 1'b0;
    #1;
    check("arst_status", status_m, 0);
    check("arst_gold_ready", m.gold_ready, 0);
    check("arst_dut_ready", m.dut_ready, 0);
    @(negedge CLK);
    _RESET = 1'b1;
    @(negedge CLK);
    m.dut_valid = 1'b1; m.dut_data = W'(1);
    @(negedge CLK);
    m.dut_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("arst_flush_match", match_cnt_m, 0);
    check("arst_flush_err", err_cnt_m, 0);
    check("arst_flush_status", status_m, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
